// File: rtl/mem_seq_ctrl.sv
// mem_seq_ctrl: valid/ready host sequencer generating registered strobes for a 32x8 asynchronous RAM
module mem_seq_ctrl #(
    parameter int AW      = 5,
    parameter int DW      = 8,
    parameter int RD_WAIT = 1
) (
    input  logic          clk,
    input  logic          rst_,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic          busy,
    output logic [AW-1:0] mem_addr,
    output logic          mem_read,
    output logic          mem_write,
    inout  wire  [DW-1:0] mem_data
);
    typedef enum logic [2:0] {IDLE, W_SETUP, W_PULSE, W_HOLD, R_ACCESS} state_t;
    state_t        state;
    logic [2:0]    cnt;
    logic          drive;
    logic [DW-1:0] wdata_q;
    assign req_ready = state == IDLE && rst_;
    assign busy      = state != IDLE;
    assign mem_data  = drive ? wdata_q : {DW{1'bz}};
    // drive spans setup, pulse and hold so data brackets the rising mem_write edge
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            drive     <= 1'b0;
            wdata_q   <= '0;
            mem_addr  <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: if (req_valid) begin
                    mem_addr <= req_addr;
                    cnt      <= 3'(RD_WAIT);
                    if (req_we) begin
                        state   <= W_SETUP;
                        wdata_q <= req_wdata;
                        drive   <= 1'b1;
                    end else begin
                        state    <= R_ACCESS;
                        mem_read <= 1'b1;
                    end
                end
                W_SETUP: begin
                    state     <= W_PULSE;
                    mem_write <= 1'b1;
                end
                W_PULSE: begin
                    state     <= W_HOLD;
                    mem_write <= 1'b0;
                end
                W_HOLD: begin
                    state     <= IDLE;
                    drive     <= 1'b0;
                    rsp_valid <= 1'b1;
                end
                R_ACCESS: if (cnt == 3'd0) begin
                    state     <= IDLE;
                    mem_read  <= 1'b0;
                    rsp_valid <= 1'b1;
                    rsp_rdata <= mem_data;
                end else cnt <= cnt - 3'd1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_seq_ctrl.sv
// tb_mem_seq_ctrl: directed bench with a 32x8 async RAM model and a bus probe for the floating check
module tb_mem_seq_ctrl;
    localparam int RW = 1;
    logic clk = 1'b0;
    logic rst_ = 1'b0;
    always #5 clk = ~clk;
    logic       req_valid = 1'b0, req_we = 1'b0;
    logic [4:0] req_addr = 5'd0;
    logic [7:0] req_wdata = 8'd0;
    wire        req_ready, rsp_valid, busy, mem_read, mem_write;
    wire  [7:0] rsp_rdata, mem_data;
    wire  [4:0] mem_addr;
    logic       probe = 1'b0;
    logic [7:0] ram [32] = '{default: 8'h00};
    logic [7:0] last_rd = 8'h00;
    int n_vec = 0, n_bad = 0;

    assign mem_data = mem_read ? ram[mem_addr] : 8'hzz;
    // probe only pulls the bus when the DUT must be floating; any DUT drive corrupts the value
    assign mem_data = probe ? 8'h3c : 8'hzz;
    always @(posedge mem_write) ram[mem_addr] <= mem_data;

    mem_seq_ctrl #(.AW(5), .DW(8), .RD_WAIT(RW)) u_dut (
        .clk(clk), .rst_(rst_), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .busy(busy), .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write), .mem_data(mem_data));

    logic       v3 = 1'b0;
    logic [4:0] a3 = 5'd0;
    wire        rdy3, rv3, busy3, mr3, mw3;
    wire  [7:0] rd3, md3;
    wire  [4:0] ma3;
    assign md3 = mr3 ? 8'h96 : 8'hzz;

    mem_seq_ctrl #(.AW(5), .DW(8), .RD_WAIT(3)) u_dut3 (
        .clk(clk), .rst_(rst_), .req_valid(v3), .req_ready(rdy3), .req_we(1'b0),
        .req_addr(a3), .req_wdata(8'h00), .rsp_valid(rv3), .rsp_rdata(rd3),
        .busy(busy3), .mem_addr(ma3), .mem_read(mr3), .mem_write(mw3), .mem_data(md3));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) if (rst_) begin
        chk("rw_excl", mem_read & mem_write, 0);
        chk("rw_excl3", mr3 & mw3, 0);
        if (mem_read) chk("rd_bus", mem_data, ram[mem_addr]);
        if (mr3) chk("rd_bus3", md3, 8'h96);
    end

    task automatic xfer(input logic we, input logic [4:0] a, input logic [7:0] d);
        chk("ready", req_ready, 1);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        @(negedge clk);
        req_valid = 1'b0;
        chk("busy", busy, 1);
        chk("addr", mem_addr, a);
        if (we) begin
            chk("setup_we", mem_write, 0);
            chk("setup_d", mem_data, d);
            @(negedge clk);
            chk("pulse_we", mem_write, 1);
            chk("pulse_d", mem_data, d);
            @(negedge clk);
            chk("hold_we", mem_write, 0);
            chk("hold_d", mem_data, d);
            chk("hold_rsp", rsp_valid, 0);
        end else begin
            for (int i = 0; i <= RW; i++) begin
                chk("rd_en", mem_read, 1);
                chk("rd_rsp", rsp_valid, 0);
                if (i < RW) @(negedge clk);
            end
            last_rd = d;
        end
        @(negedge clk);
        chk("rsp_v", rsp_valid, 1);
        chk("rsp_busy", busy, 0);
        chk("rsp_d", rsp_rdata, last_rd);
        chk("rd_off", mem_read, 0);
        if (we) begin
            probe = 1'b1;
            #1 chk("bus_z", mem_data, 8'h3c);
            probe = 1'b0;
        end
    endtask

    initial begin
        @(negedge clk);
        chk("rst_ready", req_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp", rsp_valid, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_rd", mem_read, 0);
        chk("rst_wr", mem_write, 0);
        chk("rst_addr", mem_addr, 0);
        probe = 1'b1;
        #1 chk("rst_bus", mem_data, 8'h3c);
        probe = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_ = 1'b1;
        #1 chk("rel_ready", req_ready, 1);
        chk("rel_ready3", rdy3, 1);
        xfer(1'b1, 5'd3, 8'ha5);
        xfer(1'b0, 5'd3, 8'ha5);
        xfer(1'b1, 5'd31, 8'hff);
        xfer(1'b1, 5'd0, 8'h00);
        xfer(1'b0, 5'd31, 8'hff);
        xfer(1'b0, 5'd0, 8'h00);
        // held request: address/data wiggle during the write, then turns into a read of 5
        req_valid = 1'b1; req_we = 1'b1; req_addr = 5'd5; req_wdata = 8'h77;
        @(negedge clk);
        req_addr = 5'd9; req_wdata = 8'hee;
        chk("stall_busy", busy, 1);
        chk("stall_rdy0", req_ready, 0);
        chk("stall_addr", mem_addr, 5);
        chk("stall_d", mem_data, 8'h77);
        @(negedge clk);
        req_addr = 5'd10;
        chk("stall_rdy1", req_ready, 0);
        chk("stall_we", mem_write, 1);
        chk("stall_addr1", mem_addr, 5);
        @(negedge clk);
        req_we = 1'b0; req_addr = 5'd5;
        chk("stall_rdy2", req_ready, 0);
        chk("stall_hold", mem_data, 8'h77);
        @(negedge clk);
        chk("stall_rsp", rsp_valid, 1);
        chk("stall_rdy3", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("held_rd", mem_read, 1);
        chk("held_addr", mem_addr, 5);
        @(negedge clk);
        chk("held_rd1", mem_read, 1);
        @(negedge clk);
        chk("held_rsp", rsp_valid, 1);
        chk("held_data", rsp_rdata, 8'h77);
        last_rd = 8'h77;
        xfer(1'b0, 5'd9, 8'h00);
        xfer(1'b0, 5'd10, 8'h00);
        xfer(1'b1, 5'd7, 8'h11);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 5'd7; req_wdata = 8'h5a;
        @(negedge clk);
        req_valid = 1'b0;
        chk("ws_we", mem_write, 0);
        chk("ws_d", mem_data, 8'h5a);
        rst_ = 1'b0;
        #1 chk("mr_we", mem_write, 0);
        chk("mr_rd", mem_read, 0);
        chk("mr_busy", busy, 0);
        chk("mr_rsp", rsp_valid, 0);
        chk("mr_ready", req_ready, 0);
        probe = 1'b1;
        #1 chk("mr_bus", mem_data, 8'h3c);
        probe = 1'b0;
        @(negedge clk);
        rst_ = 1'b1;
        last_rd = 8'h00;
        #1 chk("mr_ram7", ram[7], 8'h11);
        xfer(1'b0, 5'd7, 8'h11);
        @(negedge clk);
        chk("rsp_pulse", rsp_valid, 0);
        v3 = 1'b1; a3 = 5'd12;
        @(negedge clk);
        v3 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("rw3_rd", mr3, 1);
            chk("rw3_rsp", rv3, 0);
            chk("rw3_addr", ma3, 12);
            chk("rw3_busy", busy3, 1);
            @(negedge clk);
        end
        chk("rw3_off", mr3, 0);
        chk("rw3_rv", rv3, 1);
        chk("rw3_data", rd3, 8'h96);
        @(negedge clk);
        chk("rw3_pulse", rv3, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
